// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M divide issue stage.
package div_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  localparam logic [2:0] FN_DIV  = 3'b100;
  localparam logic [2:0] FN_DIVU = 3'b101;
  localparam logic [2:0] FN_REM  = 3'b110;
  localparam logic [2:0] FN_REMU = 3'b111;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/div_special.sv
// Combinational detector for the RV32M divide cases that need no divider:
// divide-by-zero and signed INT_MIN / -1 overflow.
module div_special
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            hit,
  output logic [XLEN-1:0] result
);

  logic is_signed;
  logic is_rem;
  logic zero_div;
  logic overflow;

  always_comb begin
    is_signed = !funct3[0];
    is_rem    = funct3[1];
    zero_div  = funct3[2] && (rs2 == '0);
    overflow  = funct3[2] && is_signed && (rs1 == XLEN'(INT_MIN)) && (rs2 == '1);
    hit       = zero_div || overflow;
    result    = '0;
    // Zero divisor takes precedence; the overflow remainder is 0 and quotient is rs1 (INT_MIN)
    if (zero_div) begin
      result = is_rem ? rs1 : '1;
    end else if (overflow) begin
      result = is_rem ? '0 : rs1;
    end
  end

endmodule

// File: rtl/div_issue.sv
// Sequencing stage between EX and the SRT divider: fast-paths special cases,
// launches the divider, handles flush/timeout. DIV_REUSE_EN adds a one-entry result cache.
module div_issue
  import div_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            busy,
  output logic            div_start,
  output logic [XLEN-1:0] div_a,
  output logic [XLEN-1:0] div_b,
  output logic [1:0]      div_op,
  input  logic [XLEN-1:0] div_result,
  input  logic            div_done,
  output logic            timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      fn_q;
  logic            accept;
  logic            sp_hit;
  logic [XLEN-1:0] sp_result;
  logic            cache_hit;
  logic [XLEN-1:0] cache_result;

  assign div_op = fn_q[1:0];
  assign accept = (state == S_IDLE) && in_ready && in_valid && !flush;

  div_special #(.XLEN(XLEN)) u_special (
    .funct3 (in_funct3),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .hit    (sp_hit),
    .result (sp_result)
  );

`ifdef DIV_REUSE_EN
  logic            cache_valid;
  logic [2:0]      cache_fn;
  logic [XLEN-1:0] cache_a;
  logic [XLEN-1:0] cache_b;

  // Only genuine, unflushed divider completions are worth remembering
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid  <= 1'b0;
      cache_fn     <= '0;
      cache_a      <= '0;
      cache_b      <= '0;
      cache_result <= '0;
    end else if (state == S_WAIT && div_done && !flush) begin
      cache_valid  <= 1'b1;
      cache_fn     <= fn_q;
      cache_a      <= div_a;
      cache_b      <= div_b;
      cache_result <= div_result;
    end
  end

  assign cache_hit = cache_valid && (cache_fn == in_funct3) &&
                     (cache_a == in_rs1) && (cache_b == in_rs2);
`else
  assign cache_hit    = 1'b0;
  assign cache_result = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      fn_q        <= '0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_rd      <= '0;
      div_start   <= 1'b0;
      div_a       <= '0;
      div_b       <= '0;
      timeout_err <= 1'b0;
    end else begin
      div_start <= 1'b0;
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            fn_q     <= in_funct3;
            div_a    <= in_rs1;
            div_b    <= in_rs2;
            out_rd   <= in_rd;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (sp_hit) begin
              out_result <= sp_result;
              out_valid  <= 1'b1;
              state      <= S_HOLD;
            end else if (cache_hit) begin
              out_result <= cache_result;
              out_valid  <= 1'b1;
              state      <= S_HOLD;
            end else begin
              div_start <= 1'b1;
              state     <= S_ISSUE;
            end
          end
        end

        // The launch pulse is already on the wire here, so a flush still lets it go out
        S_ISSUE: begin
          cnt   <= '0;
          state <= flush ? S_DRAIN : S_WAIT;
        end

        S_WAIT: begin
          if (div_done || cnt == CNT_LAST) begin
            if (!div_done) begin
              timeout_err <= 1'b1;
            end
            if (flush) begin
              state    <= S_IDLE;
              busy     <= 1'b0;
              in_ready <= 1'b1;
            end else begin
              out_result <= div_done ? div_result : '0;
              out_valid  <= 1'b1;
              state      <= S_HOLD;
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (flush) begin
              state <= S_DRAIN;
            end
          end
        end

        S_HOLD: begin
          if (flush || out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end

        // Divider cannot be aborted: swallow its completion before accepting new work
        S_DRAIN: begin
          if (div_done || cnt == CNT_LAST) begin
            if (!div_done) begin
              timeout_err <= 1'b1;
            end
            busy     <= 1'b0;
            in_ready <= 1'b1;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
